// File: rtl/spad_stream_reader.sv
// spad_stream_reader: turns a (base, length, stride) request into a stream of
// scratchpad reads. Returned words land in a two-entry register FIFO that feeds
// a valid/ready output stream with a last marker and a completion pulse.
//
// Timing with out_ready held high (start seen in cycle 0):
//   read_req cycles 1..N, out_valid cycles 3..N+2, done in cycle N+3.

module spad_stream_reader #(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_BITWIDTH-1:0] base_addr,
    input  logic [ADDR_BITWIDTH:0]   length,
    input  logic [ADDR_BITWIDTH-1:0] stride,
    output logic                     busy,
    output logic                     done,
    output logic                     read_req,
    output logic [ADDR_BITWIDTH-1:0] r_addr,
    input  logic [DATA_BITWIDTH-1:0] r_data,
    output logic                     out_valid,
    output logic [DATA_BITWIDTH-1:0] out_data,
    output logic                     out_last,
    input  logic                     out_ready
);

    // Element counter is one bit wider than an address so that a full sweep of
    // 2^ADDR_BITWIDTH words fits.
    localparam int LEN_W = ADDR_BITWIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Control state
    state_t                   state_q;
    logic [LEN_W-1:0]         remain_q;    // reads still to be issued
    logic [ADDR_BITWIDTH-1:0] addr_q;      // address of the next read
    logic [ADDR_BITWIDTH-1:0] stride_q;
    logic                     done_q;

    // Read in flight: data for it is on r_data this cycle
    logic                     pend_q;
    logic                     pend_last_q;

    // Two-entry FIFO: head drives the output port, skid holds the second word
    logic                     head_valid_q, head_valid_d;
    logic                     head_last_q;
    logic [DATA_BITWIDTH-1:0] head_data_q;
    logic                     skid_valid_q, skid_valid_d;
    logic                     skid_last_q;
    logic [DATA_BITWIDTH-1:0] skid_data_q;

    // Datapath steering
    logic       pop;
    logic       push;
    logic       issue;
    logic       last_issue;
    logic [2:0] committed;
    logic       head_from_skid;
    logic       head_from_in;
    logic       skid_from_in;

    // Read-issue credit and FIFO steering for this cycle.
    // NOTE: every signal written here gets a default first, so no path through the block can infer a latch.
    always_comb begin
        pop            = 1'b0;
        push           = 1'b0;
        committed      = 3'd0;
        issue          = 1'b0;
        last_issue     = 1'b0;
        head_from_skid = 1'b0;
        head_from_in   = 1'b0;
        skid_from_in   = 1'b0;
        head_valid_d   = head_valid_q;
        skid_valid_d   = skid_valid_q;

        pop  = head_valid_q && out_ready;
        push = pend_q;

        // Words already owned by the FIFO or on their way, less the one leaving
        // now. Issuing keeps this total at most two once the new read lands, so
        // the FIFO can never overflow. The current pop is included so that a
        // continuously ready consumer still sees one word per cycle; start
        // only reaches read_req through registered state.
        committed  = 3'(head_valid_q) + 3'(skid_valid_q) + 3'(pend_q) - 3'(pop);
        issue      = (state_q == RUN) && (committed < 3'd2);
        last_issue = (remain_q == LEN_W'(1));

        // Head refills from skid when popped; incoming data goes to the head if
        // the head is (or is becoming) empty, otherwise to the skid entry.
        head_from_skid = pop && skid_valid_q;
        head_from_in   = push && (!head_valid_q || (pop && !skid_valid_q));
        skid_from_in   = push && !head_from_in;

        if (head_from_skid || head_from_in) begin
            head_valid_d = 1'b1;
        end else if (pop) begin
            head_valid_d = 1'b0;
        end

        if (skid_from_in) begin
            skid_valid_d = 1'b1;
        end else if (head_from_skid) begin
            skid_valid_d = 1'b0;
        end
    end

    // Transfer FSM: captures the request, walks the address, raises done.
    // NOTE: clocked state uses non-blocking '<=' so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            remain_q <= '0;
            addr_q   <= '0;
            stride_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q   <= base_addr;
                        stride_q <= stride;
                        remain_q <= length;
                        if (length == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        // Address wraps silently at the top of the SPad.
                        addr_q   <= addr_q + stride_q;
                        remain_q <= remain_q - LEN_W'(1);
                        if (last_issue) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && head_last_q) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Read-in-flight tracking and FIFO occupancy/last flags; reset drops any
    // word still in flight along with the FIFO contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            head_valid_q <= 1'b0;
            head_last_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_last_q  <= 1'b0;
        end else begin
            pend_q       <= issue;
            pend_last_q  <= issue && last_issue;
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;

            if (head_from_skid) begin
                head_last_q <= skid_last_q;
            end else if (head_from_in) begin
                head_last_q <= pend_last_q;
            end else if (pop) begin
                head_last_q <= 1'b0;
            end

            if (skid_from_in) begin
                skid_last_q <= pend_last_q;
            end
        end
    end

    // FIFO payload. r_data is captured only when a read is in flight, so the
    // SPad filler value never enters the buffer.
    // NOTE: payload registers are not reset; the valid flags alone decide whether their contents are meaningful.
    always_ff @(posedge clk) begin
        if (head_from_skid) begin
            head_data_q <= skid_data_q;
        end else if (head_from_in) begin
            head_data_q <= r_data;
        end

        if (skid_from_in) begin
            skid_data_q <= r_data;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign read_req  = issue;
    assign r_addr    = addr_q;
    assign out_valid = head_valid_q;
    assign out_data  = head_data_q;
    assign out_last  = head_last_q;

endmodule

// File: tb/tb_spad_stream_reader.sv
// Directed bench for spad_stream_reader. An SPad model preloaded with
// mem[k] = k + 100 answers reads one cycle later; expected addresses and
// words are queued at each start and popped as reads and handshakes occur.

module tb_spad_stream_reader;

    localparam int DW = 16;
    localparam int AW = 9;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          start     = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length    = '0;
    logic [AW-1:0] stride    = '0;
    logic          out_ready = 1'b1;
    logic          busy;
    logic          done;
    logic          read_req;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;

    spad_stream_reader #(
        .DATA_BITWIDTH(DW),
        .ADDR_BITWIDTH(AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .base_addr(base_addr),
        .length   (length),
        .stride   (stride),
        .busy     (busy),
        .done     (done),
        .read_req (read_req),
        .r_addr   (r_addr),
        .r_data   (r_data),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // SPad model: data valid exactly one cycle after read_req, filler otherwise.
    logic [DW-1:0] spad [512];
    logic          sp_v = 1'b0;
    logic [AW-1:0] sp_a = '0;

    always @(posedge clk) begin
        sp_v <= read_req;
        sp_a <= r_addr;
    end

    assign r_data = sp_v ? spad[sp_a] : 16'hDEAD;

    // Scoreboard
    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } word_t;

    word_t         exp_q[$];
    logic [AW-1:0] addr_exp_q[$];

    int            n_tests    = 0;
    int            n_fail     = 0;
    int            issued     = 0;
    int            popped     = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Per-cycle stream monitor: read addresses, buffering bound, output words,
    // stability under back-pressure.
    task automatic mon();
        word_t         w;
        logic [AW-1:0] a;
        logic          pop_now;
        pop_now = out_valid && out_ready;
        if (reset) begin
            prev_stall = 1'b0;
            return;
        end
        if (prev_stall) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(prev_data));
            check("stall_last", 32'(out_last), 32'(prev_last));
        end
        if (read_req) begin
            check("read_credit", 32'((issued - popped - int'(pop_now)) < 2), 32'd1);
            check("read_expected", 32'(addr_exp_q.size() != 0), 32'd1);
            if (addr_exp_q.size() != 0) begin
                a = addr_exp_q.pop_front();
                check("r_addr", 32'(r_addr), 32'(a));
            end
        end
        if (pop_now) begin
            check("word_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check("out_data", 32'(out_data), 32'(w.data));
                check("out_last", 32'(out_last), 32'(w.last));
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        issued     = issued + int'(read_req);
        popped     = popped + int'(pop_now);
    endtask

    // One clock cycle: drive inputs at the falling edge, sample 1 time unit later.
    task automatic cycle(input logic st, input logic rdy, input logic rst);
        @(negedge clk);
        start     = st;
        out_ready = rdy;
        reset     = rst;
        #1;
        mon();
    endtask

    task automatic push_exp(input logic [AW-1:0] b, input logic [AW:0] l, input logic [AW-1:0] s);
        logic [AW-1:0] a;
        word_t         w;
        a = b;
        for (int i = 0; i < int'(l); i++) begin
            addr_exp_q.push_back(a);
            w.data = 16'(a) + 16'd100;
            w.last = (i == int'(l) - 1);
            exp_q.push_back(w);
            a = a + s;
        end
    endtask

    task automatic flush();
        exp_q.delete();
        addr_exp_q.delete();
        issued     = 0;
        popped     = 0;
        prev_stall = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_read_req"}, 32'(read_req), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_r_addr"}, 32'(r_addr), 32'd0);
    endtask

    // Full-rate transfer with exact cycle checks; optional ignored restart.
    task automatic run_ready(input string tag, input logic [AW-1:0] b, input logic [AW:0] l,
                             input logic [AW-1:0] s, input int extra_at);
        int n;
        n         = int'(l);
        base_addr = b;
        length    = l;
        stride    = s;
        push_exp(b, l, s);
        cycle(1'b1, 1'b1, 1'b0);
        for (int c = 1; c <= n + 3; c++) begin
            if (c == extra_at) begin
                base_addr = 9'd200;
                length    = 10'd3;
                stride    = 9'd7;
                cycle(1'b1, 1'b1, 1'b0);
            end else begin
                cycle(1'b0, 1'b1, 1'b0);
            end
            check({tag, "_read_req"}, 32'(read_req), 32'(c >= 1 && c <= n));
            check({tag, "_out_valid"}, 32'(out_valid), 32'(c >= 3 && c <= n + 2));
            check({tag, "_done"}, 32'(done), 32'(c == n + 3));
            check({tag, "_busy"}, 32'(busy), 32'(c <= n + 2));
        end
        check({tag, "_words_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_reads_left"}, 32'(addr_exp_q.size()), 32'd0);
    endtask

    initial begin
        logic ready_pat [6];
        logic seen;
        for (int k = 0; k < 512; k++) begin
            spad[k] = 16'(k + 100);
        end
        ready_pat[0] = 1'b1;
        ready_pat[1] = 1'b0;
        ready_pat[2] = 1'b0;
        ready_pat[3] = 1'b1;
        ready_pat[4] = 1'b0;
        ready_pat[5] = 1'b1;

        // Reset state
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        check_idle_outputs("rst");
        cycle(1'b0, 1'b1, 1'b0);

        // Basic transfer: base 10, 4 words, stride 1
        run_ready("t1", 9'd10, 10'd4, 9'd1, 0);

        // Address wrap: 510, 1, 4
        run_ready("t2", 9'd510, 10'd3, 9'd3, 0);

        // Back-pressure: out_ready toggling 1,0,0,1,0,1,...
        base_addr = 9'd20;
        length    = 10'd6;
        stride    = 9'd2;
        push_exp(9'd20, 10'd6, 9'd2);
        cycle(1'b1, ready_pat[0], 1'b0);
        seen = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            cycle(1'b0, ready_pat[k % 6], 1'b0);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("t3_done_seen", 32'(seen), 32'd1);
        check("t3_busy_at_done", 32'(busy), 32'd0);
        check("t3_words_left", 32'(exp_q.size()), 32'd0);
        cycle(1'b0, 1'b1, 1'b0);
        check("t3_done_one_cycle", 32'(done), 32'd0);

        // Zero length: done next cycle, nothing else moves
        base_addr = 9'd50;
        length    = 10'd0;
        stride    = 9'd1;
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        check("t4_done", 32'(done), 32'd1);
        check("t4_read_req", 32'(read_req), 32'd0);
        check("t4_out_valid", 32'(out_valid), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        cycle(1'b0, 1'b1, 1'b0);
        check("t4_done_after", 32'(done), 32'd0);
        check("t4_busy_after", 32'(busy), 32'd0);

        // Reset mid-transfer after the third word, then restart at once
        flush();
        base_addr = 9'd30;
        length    = 10'd8;
        stride    = 9'd1;
        push_exp(9'd30, 10'd8, 9'd1);
        cycle(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 1'b1, 1'b0);
            if (popped >= 3) break;
        end
        check("t5_three_words", 32'(popped), 32'd3);
        cycle(1'b0, 1'b1, 1'b1);
        flush();
        base_addr = 9'd0;
        length    = 10'd2;
        stride    = 9'd1;
        push_exp(9'd0, 10'd2, 9'd1);
        cycle(1'b1, 1'b1, 1'b0);
        check_idle_outputs("t5_post_rst");
        for (int c = 1; c <= 5; c++) begin
            cycle(1'b0, 1'b1, 1'b0);
            check("t5_done", 32'(done), 32'(c == 5));
            check("t5_busy", 32'(busy), 32'(c <= 4));
        end
        check("t5_words_left", 32'(exp_q.size()), 32'd0);

        // Second start while busy is ignored
        run_ready("t6", 9'd40, 10'd5, 9'd1, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spad_stream_reader.md
SPAD_STREAM_READER -- requirements
Module: spad_stream_reader

Interface
REQ-001 SHALL have parameter DATA_BITWIDTH, default 16, SPad word width.
REQ-002 SHALL have parameter ADDR_BITWIDTH, default 9, SPad address width.
REQ-003 SHALL have the following ports (reset reset, synchronous, active-high; clock clk):
- clk  input  1  clock, all state on rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  one-cycle request to begin a transfer.
- base_addr  input  ADDR_BITWIDTH  first SPad address.
- length  input  ADDR_BITWIDTH+1  number of words to read; 0 is legal.
- stride  input  ADDR_BITWIDTH  address increment per word.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle completion pulse.
- read_req  output  1  SPad read request.
- r_addr  output  ADDR_BITWIDTH  SPad read address.
- r_data  input  DATA_BITWIDTH  SPad read data, valid exactly 1 cycle after read_req.
- out_valid  output  1  stream word available.
- out_data  output  DATA_BITWIDTH  stream word.
- out_last  output  1  marks the final word of a transfer.
- out_ready  input  1  consumer accepts the word.

Function
REQ-004 SHALL capture base_addr, length and stride on a start accepted in IDLE.
- Start in any other state SHALL be ignored.
REQ-005 SHALL implement states IDLE, RUN, DRAIN.
- IDLE->RUN on start with length!=0.
- RUN->DRAIN in the cycle the last read is issued.
- DRAIN->IDLE on the handshake of the out_last word.
REQ-006 start with length==0 SHALL stay in IDLE and pulse done in the next cycle, with no read_req and no out_valid.
REQ-007 read_req and r_addr SHALL be driven from registered state only (no combinational path from start).
- The first read_req SHALL occur in the cycle after start.
REQ-008 r_addr SHALL equal base_addr for word 0 and (previous r_addr + stride) mod 2^ADDR_BITWIDTH thereafter; wrap-around is silent.
REQ-009 SHALL sample r_data only in the cycle after a cycle with read_req=1.
- r_data in any other cycle is don't-care (SPad drives a filler value) and SHALL never enter the buffer.
REQ-010 SHALL hold returned words in a 2-entry FIFO that drives out_valid, out_data and out_last directly from registers.
REQ-011 SHALL issue a read only when (FIFO occupancy + in-flight reads − pop this cycle) < 2, where pop = out_valid && out_ready.
- The FIFO SHALL never overflow.
- With out_ready held high, throughput SHALL be 1 word/cycle.
REQ-012 Simultaneous push and pop SHALL be legal in any occupancy, including full.
REQ-013 out_data and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-014 Words SHALL be emitted in issue order.
- Latency from the start cycle to first out_valid SHALL be 3 cycles.
REQ-015 out_last SHALL be 1 only with the word of index length−1.
REQ-016 busy SHALL be 1 in RUN and DRAIN and 0 in IDLE.
REQ-017 done SHALL pulse for one cycle in the cycle after the out_last handshake, with busy already 0 in that cycle.
REQ-018 An element counter of ADDR_BITWIDTH+1 bits SHALL allow length up to 2^ADDR_BITWIDTH without overflow.

Reset
REQ-019 Reset SHALL force IDLE and set busy, done, read_req, out_valid and out_last to 0 and r_addr to 0.
- Reset SHALL empty the FIFO.
REQ-020 Reset mid-transfer SHALL abort the transfer.
- A read in flight at reset SHALL be discarded.
- No done pulse SHALL follow.
- A start in the first cycle after reset release SHALL be accepted.

Verification
REQ-021 The bench SHALL cover:
- SPad preloaded mem[k]=k+100; base=10, length=4, stride=1, out_ready=1 -> read_req cycles 1-4 at addr 10..13; out_data 110,111,112,113 on cycles 3-6; out_last on 113; done cycle 7.
- base=510, length=3, stride=3 -> r_addr 510, 1, 4 (wrap); out_data 610, 101, 104.
- length=6, out_ready toggled 1,0,0,1,0,1,... -> all 6 words in order with none lost or duplicated; read_req never leaves more than 2 words buffered plus in flight; out_data stable while stalled.
- length=0 -> done pulse next cycle; read_req, out_valid and busy stay 0.
- length=8; reset asserted after the 3rd output word -> all outputs 0 next cycle, no done pulse; a new start (base=0, length=2) yields 100, 101 correctly.
- Second start while busy with different base -> ignored; the original sequence completes unchanged.
